keycode_event_pio: RTL and testbench

- Parametrised successor to the single-register keycode input PIO.
- Synchronises a WIDTH-bit keycode input and detects value changes.
- Queues each new value in a DEPTH-entry FIFO and exposes data, status, interrupt mask and control registers on an Avalon-MM slave.
- Raises an IRQ so the NIOS software no longer misses fast keypresses between polls.

---
 rtl/keycode_event_pio_pkg.sv | 29 ++
 rtl/keycode_event_pio_if.sv | 11 +
 rtl/keycode_event_pio_sync_fifo_sc.sv | 54 +++++
 rtl/keycode_event_pio.sv | 125 ++++++++++++
 tb/tb_keycode_event_pio.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keycode_event_pio_pkg.sv
// Shared register map, status/control bit positions and sizing helper for
// the keycode event PIO.
package keycode_event_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_FIFO     = 3'd1,
    ADDR_STATUS   = 3'd2,
    ADDR_IRQ_MASK = 3'd3,
    ADDR_CONTROL  = 3'd4
  } reg_addr_e;

  localparam int CNT_LSB   = 0;
  localparam int EMPTY_BIT = 8;
  localparam int FULL_BIT  = 9;
  localparam int OVF_BIT   = 10;

  localparam int IRQ_NE_BIT  = 0;
  localparam int IRQ_OVF_BIT = 1;

  localparam int CAP_EN_BIT = 0;
  localparam int FLUSH_BIT  = 1;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/keycode_event_pio_if.sv
// Avalon-MM register port of the keycode event PIO.
interface keycode_event_pio_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/keycode_event_pio_sync_fifo_sc.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is dropped
// unless a pop retires the head on the same edge.
module sync_fifo_sc
  import keycode_event_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // When full, a same-edge pop frees the slot the write pointer already names.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/keycode_event_pio.sv
// Keycode input PIO: synchronises the keycode, queues every change in a FIFO
// and exposes data/status/mask/control registers plus a level interrupt.
module keycode_event_pio
  import keycode_event_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter bit IGNORE_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  keycode_event_pio_if.slave  bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic             change;
  logic             capture_en;
  logic             overflow;
  logic [1:0]       mask;
  logic             fifo_pop;
  logic             flush;
  logic             ovf_set;
  logic             ovf_clr;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= s2;
    end
  end

  // prev follows s2 unconditionally, so a value seen while capture is off
  // does not reappear as a change once capture is re-enabled.
  assign change = (s2 != prev) && capture_en && !(IGNORE_ZERO && (s2 == '0));

  assign fifo_pop = bus.read  && (bus.address == ADDR_FIFO);
  assign flush    = bus.write && (bus.address == ADDR_CONTROL) && bus.writedata[FLUSH_BIT];
  assign ovf_set  = change && full && !fifo_pop && !flush;
  assign ovf_clr  = bus.write && (bus.address == ADDR_STATUS) && bus.writedata[OVF_BIT];

  sync_fifo_sc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .din   (s2),
    .pop   (fifo_pop),
    .flush (flush),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      mask       <= 2'b00;
      capture_en <= 1'b1;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (bus.write && (bus.address == ADDR_IRQ_MASK)) begin
        mask[IRQ_NE_BIT]  <= bus.writedata[IRQ_NE_BIT];
        mask[IRQ_OVF_BIT] <= bus.writedata[IRQ_OVF_BIT];
      end
      if (bus.write && (bus.address == ADDR_CONTROL))
        capture_en <= bus.writedata[CAP_EN_BIT];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = s2;
      ADDR_FIFO: begin
        if (!empty) begin
          rd_mux[31]          = 1'b1;
          rd_mux[WIDTH-1:0]   = head;
        end
      end
      ADDR_STATUS: begin
        rd_mux[CNT_LSB +: CW] = count;
        rd_mux[EMPTY_BIT]     = empty;
        rd_mux[FULL_BIT]      = full;
        rd_mux[OVF_BIT]       = overflow;
      end
      ADDR_IRQ_MASK: begin
        rd_mux[IRQ_NE_BIT]  = mask[IRQ_NE_BIT];
        rd_mux[IRQ_OVF_BIT] = mask[IRQ_OVF_BIT];
      end
      ADDR_CONTROL: rd_mux[CAP_EN_BIT] = capture_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         bus.readdata <= '0;
    else if (bus.read) bus.readdata <= rd_mux;
  end

  assign irq = (mask[IRQ_NE_BIT] & !empty) | (mask[IRQ_OVF_BIT] & overflow);

  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_keycode_event_pio.sv
// Bench for keycode_event_pio: two instances (IGNORE_ZERO 0 and 1) share one
// keycode input and identical bus traffic, checked against a queue model.
module tb_keycode_event_pio;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic       irq0;
  logic       irq1;
  int         checks = 0;
  int         failures = 0;

  keycode_event_pio_if bus0 ();
  keycode_event_pio_if bus1 ();

  keycode_event_pio #(.WIDTH(8), .DEPTH(16), .IGNORE_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0));
  keycode_event_pio #(.WIDTH(8), .DEPTH(16), .IGNORE_ZERO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq1));

  always #5 clk = ~clk;

  // Reference model: one queue per instance plus software-visible flags.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         ovf0, ovf1, cap_en;
  logic [1:0] mask;
  logic [7:0] last;

  function automatic void model_key(input logic [7:0] v);
    if (cap_en && v != last) begin
      if (q0.size() < 16) q0.push_back(v); else ovf0 = 1'b1;
      if (v != 8'h00) begin
        if (q1.size() < 16) q1.push_back(v); else ovf1 = 1'b1;
      end
    end
    last = v;
  endfunction

  function automatic logic [31:0] status_exp(input int n, input bit ovf);
    return 32'(n) | ((n == 0) ? 32'h100 : 32'h0) | ((n == 16) ? 32'h200 : 32'h0)
           | (ovf ? 32'h400 : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = 3'd0; bus0.writedata = 32'h0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = 3'd0; bus1.writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
    bus0.address = a; bus1.address = a;
    bus0.read = 1'b1; bus1.read = 1'b1;
    cyc();
    r0 = bus0.readdata; r1 = bus1.readdata;
    bus0.read = 1'b0; bus1.read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus0.address = a; bus1.address = a;
    bus0.writedata = d; bus1.writedata = d;
    bus0.write = 1'b1; bus1.write = 1'b1;
    cyc();
    bus0.write = 1'b0; bus1.write = 1'b0;
  endtask

  task automatic key(input logic [7:0] v);
    in_port = v;
    repeat (4) cyc();
    model_key(v);
  endtask

  task automatic fifo_read_check(input string tag);
    logic [31:0] e0, e1, r0, r1;
    e0 = 32'h0; e1 = 32'h0;
    if (q0.size() > 0) e0 = {1'b1, 23'h0, q0.pop_front()};
    if (q1.size() > 0) e1 = {1'b1, 23'h0, q1.pop_front()};
    bus_read(3'd1, r0, r1);
    check({tag, "_iz0"}, r0, e0);
    check({tag, "_iz1"}, r1, e1);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r0, r1;
    bus_read(3'd2, r0, r1);
    check({tag, "_iz0"}, r0, status_exp(q0.size(), ovf0));
    check({tag, "_iz1"}, r1, status_exp(q1.size(), ovf1));
  endtask

  task automatic check_irq(input string tag);
    bit e0, e1;
    e0 = (mask[0] && q0.size() != 0) || (mask[1] && ovf0);
    e1 = (mask[0] && q1.size() != 0) || (mask[1] && ovf1);
    check({tag, "_iz0"}, {31'h0, irq0}, {31'h0, e0});
    check({tag, "_iz1"}, {31'h0, irq1}, {31'h0, e1});
  endtask

  task automatic drain(input string tag);
    int n;
    n = (q0.size() > q1.size()) ? q0.size() : q1.size();
    for (int i = 0; i <= n; i++) fifo_read_check(tag);
  endtask

  task automatic w_mask(input logic [1:0] m);
    logic [31:0] r0, r1;
    bus_write(3'd3, {30'h0, m});
    mask = m;
    bus_read(3'd3, r0, r1);
    check("mask_rb", r0, {30'h0, mask});
  endtask

  task automatic w_ctrl(input logic [31:0] d);
    bus_write(3'd4, d);
    if (d[1]) begin q0.delete(); q1.delete(); end
    cap_en = d[0];
  endtask

  task automatic w_w1c();
    bus_write(3'd2, 32'h400);
    ovf0 = 1'b0; ovf1 = 1'b0;
  endtask

  initial begin
    logic [31:0] r0, r1;
    idle();
    reset = 1'b1;
    in_port = 8'h1C;
    q0.delete(); q1.delete();
    ovf0 = 1'b0; ovf1 = 1'b0; cap_en = 1'b1; mask = 2'b00; last = 8'h00;
    repeat (3) cyc();
    check("rst_readdata", bus0.readdata, 32'h0);
    check("rst_irq", {31'h0, irq0}, 32'h0);

    // Nonzero key present at reset release is queued exactly once.
    reset = 1'b0;
    repeat (6) cyc();
    model_key(8'h1C);
    check_status("t1_status");
    bus_read(3'd0, r0, r1);
    check("t1_data", r0, 32'h1C);
    fifo_read_check("t1_pop");
    cyc();
    check("t1_hold", bus0.readdata, 32'h8000001C);
    fifo_read_check("t1_pop_empty");
    bus_read(3'd4, r0, r1);
    check("t1_ctrl", r0, 32'h1);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, r0, r1);
    check("t1_addr5", r0, 32'h0);

    // Release code handling differs between the two instances.
    key(8'h00);
    drain("t2_pre");
    key(8'h1C); key(8'h00); key(8'h23);
    check_status("t2_status");
    drain("t2_pop");

    // Overflow: 17 changes into 16 entries.
    for (int i = 0; i < 17; i++) key(8'h40 + 8'(i));
    check_status("t3_status_full_ovf");
    bus_read(3'd2, r0, r1);
    check("t3_status_lit", r0, 32'h610);
    w_w1c();
    check_status("t3_status_w1c");

    // Full FIFO: change and pop on the same edge.
    in_port = 8'h77;
    cyc(); cyc();
    fifo_read_check("t4_pop_push");
    model_key(8'h77);
    cyc();
    check_status("t4_status");
    drain("t4_drain");

    // Non-empty interrupt timing.
    w_mask(2'b01);
    check_irq("t5_idle");
    in_port = 8'h31;
    cyc(); cyc();
    check_irq("t5_before_push");
    cyc();
    model_key(8'h31);
    check_irq("t5_at_push");
    check("t5_irq_lit", {31'h0, irq0}, 32'h1);
    fifo_read_check("t5_pop");
    check_irq("t5_after_pop");

    // Overflow interrupt holds until W1C.
    w_mask(2'b10);
    for (int i = 0; i < 16; i++) key(8'h50 + 8'(i));
    check_irq("t5_full_no_ovf");
    key(8'h60);
    check_irq("t5_ovf");
    drain("t5_drain");
    check_irq("t5_ovf_held");
    w_w1c();
    check_irq("t5_ovf_cleared");
    w_mask(2'b00);

    // Flush coinciding with a push.
    for (int i = 0; i < 5; i++) key(8'h10 + 8'(i));
    check_status("t6_five");
    in_port = 8'h2A;
    cyc(); cyc();
    w_ctrl(32'h3);
    last = 8'h2A;
    cyc();
    check_status("t6_flushed");
    bus_read(3'd4, r0, r1);
    check("t6_ctrl", r0, 32'h1);
    key(8'h2B);
    check_status("t6_after");
    drain("t6_drain");

    // Capture disabled: change is absorbed, not replayed on re-enable.
    w_ctrl(32'h0);
    key(8'h44);
    check_status("t7_cap_off");
    w_ctrl(32'h1);
    key(8'h44);
    check_status("t7_cap_on_same");
    key(8'h45);
    drain("t7_drain");

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: key(8'($urandom_range(0, 5)));
        3: fifo_read_check("rnd_pop");
        4: begin
          bus_read(3'd0, r0, r1);
          check("rnd_data", r0, {24'h0, last});
          check_status("rnd_status");
        end
        5: w_mask(2'($urandom_range(0, 3)));
        6: w_ctrl({30'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)});
        default: w_w1c();
      endcase
      check_irq("rnd_irq");
    end
    check_status("rnd_final");
    drain("rnd_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
